lsu_dccm_mem: RTL and testbench

Responder side of the LSU DCCM port: a word-interleaved, banked data memory that accepts the single write and dual (lo/hi) read requests issued by the LSU DCCM control logic in DC1. It returns the stored data-plus-ECC words one cycle later, in DC2. Stored ECC bits are passed through untouched. It also flags bank-usage violations that the initiator's arbitration must never produce.

---
 rtl/lsu_dccm_mem.sv | 131 +++++++++++++
 tb/tb_lsu_dccm_mem.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_dccm_mem.sv
`default_nettype none
// ============================================================================
// Module   : lsu_dccm_mem
// Purpose  : Word-interleaved, banked DCCM data memory. It accepts one write
//            and a lo/hi read pair per cycle in DC1 and returns registered
//            read words in DC2. Stored words are {ecc, data} and are kept
//            as opaque bits. Bank-usage violations are flagged and counted.
// Ports    : clk, rst_l (async assert, active-low)
//            dccm_wren / dccm_wr_addr / dccm_wr_data   : write request
//            dccm_rden / dccm_rd_addr_lo / _hi         : dual read request
//            dccm_rd_data_lo / dccm_rd_data_hi         : read words (DC2)
//            dccm_bank_conflict                        : 1-cycle violation pulse
//            dccm_conflict_cnt                         : saturating event count
// Revision : 1.0 - initial release
// ============================================================================
module lsu_dccm_mem #(
  parameter int DCCM_BITS   = 16,
  parameter int NUM_BANKS   = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int FDATA_WIDTH = 39
) (
  input  logic                   clk,
  input  logic                   rst_l,
  input  logic                   dccm_wren,
  input  logic                   dccm_rden,
  input  logic [DCCM_BITS-1:0]   dccm_wr_addr,
  input  logic [DCCM_BITS-1:0]   dccm_rd_addr_lo,
  input  logic [DCCM_BITS-1:0]   dccm_rd_addr_hi,
  input  logic [FDATA_WIDTH-1:0] dccm_wr_data,
  output logic [FDATA_WIDTH-1:0] dccm_rd_data_lo,
  output logic [FDATA_WIDTH-1:0] dccm_rd_data_hi,
  output logic                   dccm_bank_conflict,
  output logic [7:0]             dccm_conflict_cnt
);

  localparam int BANKW  = $clog2(NUM_BANKS);
  localparam int IDXW   = DCCM_BITS - 2 - BANKW;
  localparam int DEPTH  = 1 << IDXW;
  // A stored word is ECC bits on top of the data bits; never interpreted here.
  localparam int ECC_W  = FDATA_WIDTH - DATA_WIDTH;
  localparam int WORD_W = ECC_W + DATA_WIDTH;

  // Address decode: byte offset ignored, bank is the low word-address bits.
  logic [BANKW-1:0] w_wr_bank, w_lo_bank, w_hi_bank;
  logic [IDXW-1:0]  w_wr_idx,  w_lo_idx,  w_hi_idx;

  assign w_wr_bank = dccm_wr_addr[2 +: BANKW];
  assign w_lo_bank = dccm_rd_addr_lo[2 +: BANKW];
  assign w_hi_bank = dccm_rd_addr_hi[2 +: BANKW];
  assign w_wr_idx  = dccm_wr_addr[DCCM_BITS-1 : 2+BANKW];
  assign w_lo_idx  = dccm_rd_addr_lo[DCCM_BITS-1 : 2+BANKW];
  assign w_hi_idx  = dccm_rd_addr_hi[DCCM_BITS-1 : 2+BANKW];

  logic w_unused_byte_offs;
  assign w_unused_byte_offs = ^{dccm_wr_addr[1:0], dccm_rd_addr_lo[1:0],
                                dccm_rd_addr_hi[1:0]};

  logic [WORD_W-1:0] w_bank_rdata [NUM_BANKS];

  // Each bank has a single address port. Priority write > lo > hi makes the
  // illegal cases fall out naturally: a read that collides with a write sees
  // the (old) word at the write index, and a hi read sharing the lo bank
  // sees the lo word.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic              w_wr_sel;
    logic              w_lo_sel;
    logic [IDXW-1:0]   w_idx;

    assign w_wr_sel = dccm_wren && (w_wr_bank == BANKW'(b));
    assign w_lo_sel = (w_lo_bank == BANKW'(b));
    assign w_idx    = w_wr_sel ? w_wr_idx : (w_lo_sel ? w_lo_idx : w_hi_idx);

    // Asynchronous array read, captured by the output registers below;
    // the write lands at the same edge, giving read-before-write.
    assign w_bank_rdata[b] = mem_q[w_idx];

    always_ff @(posedge clk) begin
      if (w_wr_sel) begin
        mem_q[w_idx] <= dccm_wr_data;
      end
    end
  end

  logic w_conf_wr, w_conf_rd, w_conflict;

  assign w_conf_wr = dccm_wren && dccm_rden &&
                     (((w_wr_bank == w_lo_bank) && (w_wr_idx != w_lo_idx)) ||
                      ((w_wr_bank == w_hi_bank) && (w_wr_idx != w_hi_idx)));
  assign w_conf_rd = dccm_rden && (w_lo_bank == w_hi_bank) && (w_lo_idx != w_hi_idx);
  assign w_conflict = w_conf_wr || w_conf_rd;

  logic [WORD_W-1:0] rd_lo_q, rd_lo_d;
  logic [WORD_W-1:0] rd_hi_q, rd_hi_d;
  logic              conflict_q;
  logic [7:0]        cnt_q, cnt_d;

  always_comb begin
    rd_lo_d = rd_lo_q;
    rd_hi_d = rd_hi_q;
    if (dccm_rden) begin
      rd_lo_d = w_bank_rdata[w_lo_bank];
      rd_hi_d = w_bank_rdata[w_hi_bank];
    end
    cnt_d = cnt_q;
    if (w_conflict && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rd_lo_q    <= '0;
      rd_hi_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      rd_lo_q    <= rd_lo_d;
      rd_hi_q    <= rd_hi_d;
      conflict_q <= w_conflict;
      cnt_q      <= cnt_d;
    end
  end

  assign dccm_rd_data_lo    = rd_lo_q;
  assign dccm_rd_data_hi    = rd_hi_q;
  assign dccm_bank_conflict = conflict_q;
  assign dccm_conflict_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dccm_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_dccm_mem
// Purpose  : Directed, table-driven bench for lsu_dccm_mem (default params:
//            bank = addr[4:2], index = addr[15:5]) plus hand-written reset and
//            counter-saturation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_dccm_mem;

  localparam int DB = 16;
  localparam int FW = 39;

  logic          clk = 1'b0;
  logic          rst_l = 1'b0;
  logic          dccm_wren = 1'b0;
  logic          dccm_rden = 1'b0;
  logic [DB-1:0] dccm_wr_addr = '0;
  logic [DB-1:0] dccm_rd_addr_lo = '0;
  logic [DB-1:0] dccm_rd_addr_hi = '0;
  logic [FW-1:0] dccm_wr_data = '0;
  logic [FW-1:0] dccm_rd_data_lo;
  logic [FW-1:0] dccm_rd_data_hi;
  logic          dccm_bank_conflict;
  logic [7:0]    dccm_conflict_cnt;

  lsu_dccm_mem #(
    .DCCM_BITS(16), .NUM_BANKS(8), .DATA_WIDTH(32), .FDATA_WIDTH(39)
  ) dut (
    .clk                (clk),
    .rst_l              (rst_l),
    .dccm_wren          (dccm_wren),
    .dccm_rden          (dccm_rden),
    .dccm_wr_addr       (dccm_wr_addr),
    .dccm_rd_addr_lo    (dccm_rd_addr_lo),
    .dccm_rd_addr_hi    (dccm_rd_addr_hi),
    .dccm_wr_data       (dccm_wr_data),
    .dccm_rd_data_lo    (dccm_rd_data_lo),
    .dccm_rd_data_hi    (dccm_rd_data_hi),
    .dccm_bank_conflict (dccm_bank_conflict),
    .dccm_conflict_cnt  (dccm_conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wren;
    logic          rden;
    logic [DB-1:0] wa;
    logic [FW-1:0] wd;
    logic [DB-1:0] lo;
    logic [DB-1:0] hi;
    logic [FW-1:0] exp_lo;
    logic [FW-1:0] exp_hi;
    logic          exp_conf;
    logic [7:0]    exp_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic wren, input logic rden, input logic [DB-1:0] wa,
                     input logic [FW-1:0] wd, input logic [DB-1:0] lo,
                     input logic [DB-1:0] hi, input logic [FW-1:0] elo,
                     input logic [FW-1:0] ehi, input logic econf, input logic [7:0] ecnt);
    vec_t v;
    v.wren = wren; v.rden = rden; v.wa = wa; v.wd = wd; v.lo = lo; v.hi = hi;
    v.exp_lo = elo; v.exp_hi = ehi; v.exp_conf = econf; v.exp_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wren, input logic rden, input logic [DB-1:0] wa,
                       input logic [FW-1:0] wd, input logic [DB-1:0] lo,
                       input logic [DB-1:0] hi);
    dccm_wren = wren; dccm_rden = rden; dccm_wr_addr = wa; dccm_wr_data = wd;
    dccm_rd_addr_lo = lo; dccm_rd_addr_hi = hi;
  endtask

  localparam logic [FW-1:0] D_BEEF = 39'h55_DEADBEEF;
  localparam logic [FW-1:0] D_11   = 39'h11_00000011;
  localparam logic [FW-1:0] D_22   = 39'h22_00000022;
  localparam logic [FW-1:0] D_1234 = 39'h01_12345678;
  localparam logic [FW-1:0] D_CAFE = 39'h7F_CAFEF00D;
  localparam logic [FW-1:0] D_33   = 39'h33_AAAA5555;
  localparam logic [FW-1:0] D_44   = 39'h44_01020304;
  localparam logic [FW-1:0] D_66   = 39'h66_00000066;
  localparam logic [FW-1:0] D_0A   = 39'h0A_0000000A;

  initial begin
    // Each row: inputs for one cycle, then outputs expected just after that edge.
    //    wren rden wa        wd      lo        hi        exp_lo  exp_hi  conf cnt
    add(1, 0, 16'h0100, D_BEEF, 16'h0000, 16'h0000, '0,     '0,     0, 0);
    add(0, 1, 16'h0000, '0,     16'h0100, 16'h0100, D_BEEF, D_BEEF, 0, 0);
    add(1, 0, 16'h0104, D_11,   16'h0000, 16'h0000, D_BEEF, D_BEEF, 0, 0);
    add(1, 0, 16'h0108, D_22,   16'h0000, 16'h0000, D_BEEF, D_BEEF, 0, 0);
    add(0, 1, 16'h0000, '0,     16'h0104, 16'h0108, D_11,   D_22,   0, 0);
    add(1, 0, 16'h0200, D_1234, 16'h0000, 16'h0000, D_11,   D_22,   0, 0);
    // same-cycle read/write of one word: old value returned
    add(1, 1, 16'h0200, D_CAFE, 16'h0200, 16'h0200, D_1234, D_1234, 0, 0);
    add(0, 1, 16'h0000, '0,     16'h0200, 16'h0200, D_CAFE, D_CAFE, 0, 0);
    add(0, 1, 16'h0000, '0,     16'h0104, 16'h0104, D_11,   D_11,   0, 0);
    // hold for 3 cycles while the read word is overwritten
    add(1, 0, 16'h0104, D_33,   16'h0000, 16'h0000, D_11,   D_11,   0, 0);
    add(1, 0, 16'h0104, D_33,   16'h0000, 16'h0000, D_11,   D_11,   0, 0);
    add(1, 0, 16'h0104, D_33,   16'h0000, 16'h0000, D_11,   D_11,   0, 0);
    add(0, 1, 16'h0000, '0,     16'h0104, 16'h0104, D_33,   D_33,   0, 0);
    // lo/hi same bank, different index: hi gets lo word
    add(0, 1, 16'h0000, '0,     16'h0104, 16'h0124, D_33,   D_33,   1, 1);
    add(0, 0, 16'h0000, '0,     16'h0000, 16'h0000, D_33,   D_33,   0, 1);
    // write bank 0 idx 8 vs lo bank 0 idx 9: lo sees old word at 0x0100
    add(1, 1, 16'h0100, D_44,   16'h0120, 16'h0108, D_BEEF, D_22,   1, 2);
    add(0, 1, 16'h0000, '0,     16'h0100, 16'h0100, D_44,   D_44,   0, 2);
    // write bank 2 idx 8 vs hi bank 2 idx 9: hi sees old word at 0x0108
    add(1, 1, 16'h0108, D_66,   16'h0104, 16'h0128, D_33,   D_22,   1, 3);
    add(0, 1, 16'h0000, '0,     16'h0108, 16'h0100, D_66,   D_44,   0, 3);
    // write to an unrelated bank while reading: no conflict
    add(1, 1, 16'h010C, D_0A,   16'h0100, 16'h0108, D_44,   D_66,   0, 3);
    add(0, 1, 16'h0000, '0,     16'h010C, 16'h010C, D_0A,   D_0A,   0, 3);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_lo",   64'(dccm_rd_data_lo),    64'd0);
    check("reset_hi",   64'(dccm_rd_data_hi),    64'd0);
    check("reset_conf", 64'(dccm_bank_conflict), 64'd0);
    check("reset_cnt",  64'(dccm_conflict_cnt),  64'd0);
    @(negedge clk);
    rst_l = 1'b1;

    // Table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].wren, vecs[i].rden, vecs[i].wa, vecs[i].wd, vecs[i].lo, vecs[i].hi);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_lo", i),   64'(dccm_rd_data_lo),    64'(vecs[i].exp_lo));
      check($sformatf("vec%0d_hi", i),   64'(dccm_rd_data_hi),    64'(vecs[i].exp_hi));
      check($sformatf("vec%0d_conf", i), 64'(dccm_bank_conflict), 64'(vecs[i].exp_conf));
      check($sformatf("vec%0d_cnt", i),  64'(dccm_conflict_cnt),  64'(vecs[i].exp_cnt));
    end

    // Asynchronous reset with a read in flight
    @(negedge clk);
    drive(0, 1, 16'h0000, '0, 16'h0108, 16'h0108);
    #2;
    rst_l = 1'b0;
    #1;
    check("async_rst_lo",  64'(dccm_rd_data_lo),    64'd0);
    check("async_rst_hi",  64'(dccm_rd_data_hi),    64'd0);
    check("async_rst_cnt", 64'(dccm_conflict_cnt),  64'd0);
    @(posedge clk);
    #1;
    check("rst_edge_lo",   64'(dccm_rd_data_lo),    64'd0);
    check("rst_edge_conf", 64'(dccm_bank_conflict), 64'd0);
    @(negedge clk);
    drive(0, 0, 16'h0000, '0, 16'h0000, 16'h0000);
    rst_l = 1'b1;

    // First edge after reset: conflict (write 0x0100 vs lo 0x0120), then
    // 256 more conflicts to saturate the counter.
    for (int k = 0; k < 257; k++) begin
      @(negedge clk);
      drive(1, 1, 16'h0100, 39'(k), 16'h0120, 16'h0108);
      @(posedge clk);
      #1;
      if (k == 0) begin
        check("sat_first_lo", 64'(dccm_rd_data_lo), 64'(D_44));
        check("sat_first_hi", 64'(dccm_rd_data_hi), 64'(D_66));
      end
      check($sformatf("sat%0d_conf", k), 64'(dccm_bank_conflict), 64'd1);
      check($sformatf("sat%0d_cnt", k),  64'(dccm_conflict_cnt),
            64'((k + 1 > 255) ? 255 : k + 1));
    end
    @(negedge clk);
    drive(0, 0, 16'h0000, '0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("sat_idle_conf", 64'(dccm_bank_conflict), 64'd0);
    check("sat_idle_cnt",  64'(dccm_conflict_cnt),  64'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
